// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, responder FSM states and lane geometry.
package axi4_lite_pkg;

  localparam int unsigned BYTE_LANES = 4;
  localparam int unsigned LANE_WIDTH = 8;
  localparam int unsigned WORD_WIDTH = BYTE_LANES * LANE_WIDTH;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/AXI_BUS.sv
// AXI4-Lite channel bundle with master and slave views.
interface AXI_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport Master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_ram_mem.sv
// Byte-enabled word array, cleared on reset; one write port, one combinational read port.
module axi4_lite_ram_mem
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  input  logic [BYTE_LANES-1:0] i_wstrb,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [WORD_WIDTH-1:0] o_rdata
);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < int'(BYTE_LANES); b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*LANE_WIDTH +: LANE_WIDTH] <= i_wdata[b*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Read sees the pre-edge contents, giving read-before-write on a same-word collision
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi4_lite_ram.sv
// AXI4-Lite RAM responder: independent write (AW/W/B) and read (AR/R) engines over a word array.
module axi4_lite_ram
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input logic   clk,
  input logic   rst_n,
  AXI_BUS.Slave amba_slave
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned SPAN_W = IDX_W + 2;

  wr_state_t             r_wr_state, w_wr_next;
  logic                  r_aw_valid, r_w_valid;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [BYTE_LANES-1:0] r_w_strb;
  logic                  r_bvalid;
  resp_t                 r_bresp;

  rd_state_t             r_rd_state, w_rd_next;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  resp_t                 r_rresp;

  logic                  w_awready, w_wready, w_arready;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                  w_commit, w_wr_in_range, w_rd_in_range;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data, w_mem_rdata;
  logic [BYTE_LANES-1:0] w_wr_strb;
  logic                  w_unused_ok;

  // Write channel: readies depend only on state and latch flags
  assign w_awready = (r_wr_state == W_IDLE) && !r_aw_valid;
  assign w_wready  = (r_wr_state == W_IDLE) && !r_w_valid;
  assign w_aw_hs   = amba_slave.awvalid && w_awready;
  assign w_w_hs    = amba_slave.wvalid && w_wready;
  assign w_b_hs    = r_bvalid && amba_slave.bready;
  assign w_commit  = (r_wr_state == W_IDLE) && (r_aw_valid || w_aw_hs) && (r_w_valid || w_w_hs);

  assign w_wr_addr     = r_aw_valid ? r_aw_addr : amba_slave.awaddr;
  assign w_wr_data     = r_w_valid ? r_w_data : amba_slave.wdata;
  assign w_wr_strb     = r_w_valid ? r_w_strb : amba_slave.wstrb;
  assign w_wr_in_range = (w_wr_addr >> SPAN_W) == '0;

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE: if (w_commit) w_wr_next = W_RESP;
      W_RESP: if (w_b_hs)   w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= W_IDLE;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
    end else begin
      r_wr_state <= w_wr_next;
      r_bvalid   <= (w_wr_next == W_RESP);
      if (w_commit) begin
        r_aw_valid <= 1'b0;
        r_w_valid  <= 1'b0;
        r_bresp    <= w_wr_in_range ? OKAY : SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_valid <= 1'b1;
          r_aw_addr  <= amba_slave.awaddr;
        end
        if (w_w_hs) begin
          r_w_valid <= 1'b1;
          r_w_data  <= amba_slave.wdata;
          r_w_strb  <= amba_slave.wstrb;
        end
      end
    end
  end

  // Read channel
  assign w_arready     = (r_rd_state == R_IDLE);
  assign w_ar_hs       = amba_slave.arvalid && w_arready;
  assign w_r_hs        = r_rvalid && amba_slave.rready;
  assign w_rd_in_range = (amba_slave.araddr >> SPAN_W) == '0;

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      R_IDLE: if (w_ar_hs) w_rd_next = R_DATA;
      R_DATA: if (w_r_hs)  w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= OKAY;
    end else begin
      r_rd_state <= w_rd_next;
      r_rvalid   <= (w_rd_next == R_DATA);
      if (w_ar_hs) begin
        r_rdata <= w_rd_in_range ? w_mem_rdata : '0;
        r_rresp <= w_rd_in_range ? OKAY : SLVERR;
      end
    end
  end

  axi4_lite_ram_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_commit && w_wr_in_range),
    .i_waddr (w_wr_addr[SPAN_W-1:2]),
    .i_wdata (w_wr_data),
    .i_wstrb (w_wr_strb),
    .i_raddr (amba_slave.araddr[SPAN_W-1:2]),
    .o_rdata (w_mem_rdata)
  );

  // Sub-word address bits carry no meaning for a word-organised array
  assign w_unused_ok = ^{w_wr_addr[1:0], amba_slave.araddr[1:0]};

  assign amba_slave.awready = w_awready;
  assign amba_slave.wready  = w_wready;
  assign amba_slave.bvalid  = r_bvalid;
  assign amba_slave.bresp   = r_bresp;
  assign amba_slave.arready = w_arready;
  assign amba_slave.rvalid  = r_rvalid;
  assign amba_slave.rdata   = r_rdata;
  assign amba_slave.rresp   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_ram.sv
// Randomised self-checking bench for axi4_lite_ram against a flat array reference model.
module tb_axi4_lite_ram;

  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .amba_slave (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model [DEPTH];

  function automatic bit in_range(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_range(a) ? model[a / 4] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    logic [1:0] er;
    aw_done = 0; w_done = 0; cyc = 0;
    er = exp_resp(a);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      if (aw_done) begin
        checks++;
        if (bus.awready !== 1'b0) begin errors++; $display("FAIL awready_after_latch: got %b, expected 0", bus.awready); end
      end
      if (w_done) begin
        checks++;
        if (bus.wready !== 1'b0) begin errors++; $display("FAIL wready_after_latch: got %b, expected 0", bus.wready); end
      end
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick();
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    checks++;
    if (!(aw_done && w_done)) begin errors++; $display("FAIL write_handshake_timeout: got aw=%b w=%b, expected 1 1", aw_done, w_done); end
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_latency: got %b, expected 1", bus.bvalid); end
    checks++;
    if (bus.bresp !== er) begin errors++; $display("FAIL bresp @%h: got %b, expected %b", a, bus.bresp, er); end
    model_write(a, d, s);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== er) begin
        errors++; $display("FAIL b_hold: got bvalid=%b bresp=%b, expected 1 %b", bus.bvalid, bus.bresp, er);
      end
    end
    bus.bready = 1;
    tick();
    bus.bready = 0;
    checks++;
    if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL b_release: got %b, expected 0", bus.bvalid); end
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly);
    logic [31:0] ed;
    logic [1:0] er;
    ed = model_read(a);
    er = exp_resp(a);
    bus.araddr = a; bus.arvalid = 1;
    checks++;
    if (bus.arready !== 1'b1) begin errors++; $display("FAIL arready_idle: got %b, expected 1", bus.arready); end
    tick();
    bus.arvalid = 0;
    checks++;
    if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_latency: got %b, expected 1", bus.rvalid); end
    checks++;
    if (bus.rdata !== ed) begin errors++; $display("FAIL rdata @%h: got %h, expected %h", a, bus.rdata, ed); end
    checks++;
    if (bus.rresp !== er) begin errors++; $display("FAIL rresp @%h: got %b, expected %b", a, bus.rresp, er); end
    for (int i = 0; i < r_dly; i++) begin
      tick();
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== ed) begin
        errors++; $display("FAIL r_hold: got rvalid=%b rdata=%h, expected 1 %h", bus.rvalid, bus.rdata, ed);
      end
    end
    bus.rready = 1;
    tick();
    bus.rready = 0;
    checks++;
    if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL r_release: got %b, expected 0", bus.rvalid); end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.bvalid, bus.rvalid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b, expected 00", {bus.bvalid, bus.rvalid}); end
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++; $display("FAIL reset_readies: got %b, expected 111", {bus.awready, bus.wready, bus.arready});
    end
    checks++;
    if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
      errors++; $display("FAIL reset_resp_data: got %h, expected 0", {bus.bresp, bus.rresp, bus.rdata});
    end
    do_read(32'h0, 0);
  endtask

  task automatic test_same_cycle_write();
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h10, 0);
  endtask

  task automatic test_w_before_aw();
    do_write(32'h10, 32'h1122_3344, 4'b0101, 3, 0, 0);
    checks++;
    if (model[4] !== 32'hDE22_BE44) begin errors++; $display("FAIL model_merge: got %h, expected de22be44", model[4]); end
    do_read(32'h10, 1);
    do_write(32'h14, 32'h5566_7788, 4'b1010, 0, 2, 1);
    do_read(32'h14, 0);
  endtask

  task automatic test_out_of_range();
    do_write(32'h400, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_read(32'h400, 0);
    do_read(32'h000, 0);
    do_read(32'h8000_0010, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    d = $urandom;
    bus.awaddr = 32'h30; bus.wdata = d; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
    bus.araddr = 32'h10; bus.arvalid = 1;
    tick();
    model_write(32'h30, d, 4'hF);
    bus.awaddr = 32'h34; bus.araddr = 32'h34;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.rvalid !== 1'b1 ||
          bus.rdata !== model[4] || bus.rresp !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold: got bv=%b br=%b rv=%b rd=%h rr=%b, expected 1 00 1 %h 00",
                 bus.bvalid, bus.bresp, bus.rvalid, bus.rdata, bus.rresp, model[4]);
      end
      checks++;
      if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
        errors++; $display("FAIL stall_readies: got %b, expected 000", {bus.awready, bus.wready, bus.arready});
      end
      tick();
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b00111) begin
      errors++; $display("FAIL stall_release: got %b, expected 00111",
                         {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready});
    end
    do_read(32'h30, 0);
    do_read(32'h34, 0);
  endtask

  task automatic test_read_before_write();
    logic [31:0] old;
    old = model_read(32'h20);
    bus.awaddr = 32'h20; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
    bus.araddr = 32'h20; bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    model_write(32'h20, 32'hCAFE_F00D, 4'hF);
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== old) begin
      errors++; $display("FAIL rbw_old_data: got rv=%b rd=%h, expected 1 %h", bus.rvalid, bus.rdata, old);
    end
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
      errors++; $display("FAIL rbw_bresp: got bv=%b br=%b, expected 1 00", bus.bvalid, bus.bresp);
    end
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    do_read(32'h20, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] wa, wd, ra, ed;
    bus.bready = 1; bus.rready = 1; bus.wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wa = 32'h100 + 32'(k * 4); wd = $urandom;
      ra = 32'h10 + 32'(k * 4);  ed = model_read(ra);
      bus.awaddr = wa; bus.wdata = wd; bus.araddr = ra;
      bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
      tick();
      model_write(wa, wd, 4'hF);
      checks++;
      if (bus.bvalid !== 1'b1 || bus.rvalid !== 1'b1 || bus.rdata !== ed) begin
        errors++; $display("FAIL b2b_resp %0d: got bv=%b rv=%b rd=%h, expected 1 1 %h", k, bus.bvalid, bus.rvalid, bus.rdata, ed);
      end
      tick();
      checks++;
      if ({bus.bvalid, bus.rvalid, bus.awready, bus.arready} !== 4'b0011) begin
        errors++; $display("FAIL b2b_idle %0d: got %b, expected 0011", k, {bus.bvalid, bus.rvalid, bus.awready, bus.arready});
      end
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
    for (int k = 0; k < 4; k++) do_read(32'h100 + 32'(k * 4), 0);
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(DEPTH * 4, DEPTH * 4 + 32'hFFF));
      else a = 32'($urandom_range(0, DEPTH * 4 - 1));
      d = $urandom;
      do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      do_read(a ^ 32'($urandom_range(0, 3)), $urandom_range(0, 2));
      do_read(32'($urandom_range(0, DEPTH * 4 - 1)), 0);
    end
  endtask

  task automatic test_reset_mid_write();
    do_write(32'h10, 32'h1357_9BDF, 4'hF, 0, 0, 0);
    bus.awaddr = 32'h44; bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_bvalid: got %b, expected 1", bus.bvalid); end
    rst_n = 0;
    #1;
    checks++;
    if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got bv=%b rv=%b, expected 0 0", bus.bvalid, bus.rvalid);
    end
    model_clear();
    tick();
    tick();
    rst_n = 1;
    tick();
    checks++;
    if ({bus.bvalid, bus.awready, bus.wready, bus.arready} !== 4'b0111) begin
      errors++; $display("FAIL post_reset_state: got %b, expected 0111", {bus.bvalid, bus.awready, bus.wready, bus.arready});
    end
    do_read(32'h10, 0);
    do_read(32'h20, 0);
    do_read(32'h44, 0);
    for (int i = 0; i < 4; i++) do_read(32'($urandom_range(0, DEPTH * 4 - 1)), 0);
  endtask

  initial begin
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_read_before_write();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
